alu_iterative: RTL and testbench

- Execute-stage ALU, directly downstream of the control unit's ALU decoder. It consumes the 3-bit ALUControl code and two operands, and produces a registered result plus NZCV flags.
- Add, sub, logic and shift ops complete in one cycle.
- Multiply (muli / R-type mul) uses an iterative radix-2 shift-add engine. During a multiply the block holds the pipeline off via a valid/ready handshake.

---
 rtl/alu_iterative.sv | 186 ++++++++++++++++++
 tb/tb_alu_iterative.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iterative.sv
// Execute-stage ALU. Add/sub/logic/shift finish in one cycle; multiply runs
// on an iterative radix-2 shift-add engine, one partial product per cycle,
// and holds the pipeline off through in_ready while it runs.
module alu_iterative #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_s;

    logic [WIDTH-1:0]   multiplicand_r;
    logic [WIDTH-1:0]   multiplier_r;
    logic [WIDTH-1:0]   acc_r;
    logic [SHW-1:0]     count_r;
    logic [WIDTH-1:0]   result_r;
    logic [3:0]         flags_r;
    logic               out_valid_r;

    logic               accept_s;
    logic               last_step_s;
    logic [WIDTH-1:0]   acc_next_s;
    logic [WIDTH:0]     sum_ext_s;
    logic [WIDTH-1:0]   alu_res_s;
    logic               alu_c_s;
    logic               alu_v_s;

    // Pack {N,Z,C,V}; N and Z always come from the value being registered.
    function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] res,
                                              input logic c,
                                              input logic v);
        return {res[WIDTH-1], (res == {WIDTH{1'b0}}), c, v};
    endfunction

    assign in_ready    = (state_r == IDLE);
    assign busy        = (state_r == MUL);
    assign out_valid   = out_valid_r;
    assign result      = result_r;
    assign flags       = flags_r;
    assign accept_s    = in_valid && (state_r == IDLE);
    assign last_step_s = (state_r == MUL) && (count_r == SHW'(WIDTH - 1));

    // One shift-add step: add the multiplicand when the current multiplier bit is set.
    always_comb begin
        acc_next_s = acc_r;
        if (multiplier_r[0]) begin
            acc_next_s = acc_r + multiplicand_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Single-cycle datapath; sub uses A + ~B + 1 so carry-out means "no borrow".
    always_comb begin
        sum_ext_s = {(WIDTH + 1){1'b0}};
        alu_res_s = {WIDTH{1'b0}};
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
        case (ALUControl)
            OP_ADD: begin
                sum_ext_s = {1'b0, src_a} + {1'b0, src_b};
                alu_res_s = sum_ext_s[WIDTH-1:0];
                alu_c_s   = sum_ext_s[WIDTH];
                alu_v_s   = (src_a[WIDTH-1] == src_b[WIDTH-1]) &&
                            (alu_res_s[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_SUB: begin
                sum_ext_s = {1'b0, src_a} + {1'b0, ~src_b} + {{WIDTH{1'b0}}, 1'b1};
                alu_res_s = sum_ext_s[WIDTH-1:0];
                alu_c_s   = sum_ext_s[WIDTH];
                alu_v_s   = (src_a[WIDTH-1] != src_b[WIDTH-1]) &&
                            (alu_res_s[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_AND:  alu_res_s = src_a & src_b;
            OP_OR:   alu_res_s = src_a | src_b;
            OP_XOR:  alu_res_s = src_a ^ src_b;
            OP_SLL:  alu_res_s = src_a << src_b[SHW-1:0];
            OP_SRL:  alu_res_s = src_a >> src_b[SHW-1:0];
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state: a mul request enters MUL, the final step returns to IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && (ALUControl == OP_MUL)) begin
                    state_s = MUL;
                end else begin
                    state_s = IDLE;
                end
            end
            MUL: begin
                if (last_step_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = MUL;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Datapath registers: operand latch, multiply engine, registered result/flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            multiplicand_r <= {WIDTH{1'b0}};
            multiplier_r   <= {WIDTH{1'b0}};
            acc_r          <= {WIDTH{1'b0}};
            count_r        <= {SHW{1'b0}};
            result_r       <= {WIDTH{1'b0}};
            flags_r        <= 4'b0000;
            out_valid_r    <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        if (ALUControl == OP_MUL) begin
                            multiplicand_r <= src_a;
                            multiplier_r   <= src_b;
                            acc_r          <= {WIDTH{1'b0}};
                            count_r        <= {SHW{1'b0}};
                        end else begin
                            result_r    <= alu_res_s;
                            flags_r     <= pack_flags(alu_res_s, alu_c_s, alu_v_s);
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc_r          <= acc_next_s;
                    multiplicand_r <= multiplicand_r << 1;
                    multiplier_r   <= multiplier_r >> 1;
                    count_r        <= count_r + SHW'(1);
                    if (last_step_s) begin
                        result_r    <= acc_next_s;
                        flags_r     <= pack_flags(acc_next_s, 1'b0, 1'b0);
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_iterative.sv
// Self-checking bench for alu_iterative: directed corner cases followed by
// random operations compared against an arithmetic reference model.
module tb_alu_iterative;

    localparam int W = 32;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    ALUControl;
    logic [W-1:0]  src_a;
    logic [W-1:0]  src_b;
    logic          out_valid;
    logic [W-1:0]  result;
    logic [3:0]    flags;
    logic          busy;

    int checks_r = 0;
    int errors_r = 0;

    alu_iterative #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (ALUControl),
        .src_a      (src_a),
        .src_b      (src_b),
        .out_valid  (out_valid),
        .result     (result),
        .flags      (flags),
        .busy       (busy)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r++;
        if (obs !== exp) begin
            errors_r++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain wide/signed arithmetic from the operation definitions.
    function automatic void ref_alu(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] r,
                                    output logic [3:0] f);
        longint sa;
        longint sb;
        longint s;
        logic [63:0] p;
        logic c;
        logic v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c = 1'b0;
        v = 1'b0;
        r = 32'h0;
        case (op)
            3'd0: begin
                r = a + b;
                c = (({32'h0, a} + {32'h0, b}) > 64'h0000_0000_FFFF_FFFF);
                s = sa + sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd1: begin
                r = a - b;
                c = (a >= b);
                s = sa - sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd2: begin
                p = {32'h0, a} * {32'h0, b};
                r = p[31:0];
            end
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: r = a << b[4:0];
            3'd7: r = a >> b[4:0];
            default: r = 32'h0;
        endcase
        f = {r[31], (r == 32'h0), c, v};
    endfunction

    // Present one request for one edge; returns just after the acceptance edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid   = 1'b1;
        ALUControl = op;
        src_a      = a;
        src_b      = b;
        tick();
        in_valid   = 1'b0;
    endtask

    // Issue an op and check its result; for mul also check latency and hold-off.
    // With poke set, an add with different operands is presented mid-multiply.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit poke);
        logic [31:0] er;
        logic [3:0]  ef;
        int          n;
        bit          seen;
        bit          hold_ok;
        ref_alu(op, a, b, er, ef);
        issue(op, a, b);
        if (op != 3'd2) begin
            check({tag, "_ov"}, {31'h0, out_valid}, 32'h1);
        end else begin
            check({tag, "_busy0"}, {30'h0, busy, in_ready}, 32'h2);
            n = 0;
            seen = 1'b0;
            hold_ok = 1'b1;
            while (!seen && n < 100) begin
                if (poke && n < W / 2) begin
                    in_valid   = 1'b1;
                    ALUControl = 3'd0;
                    src_a      = 32'h1234_5678;
                    src_b      = 32'h0000_0001;
                end else begin
                    in_valid   = 1'b0;
                end
                tick();
                n++;
                if (out_valid) seen = 1'b1;
                else if (in_ready !== 1'b0 || busy !== 1'b1) hold_ok = 1'b0;
            end
            in_valid = 1'b0;
            check({tag, "_seen"}, {31'h0, seen}, 32'h1);
            check({tag, "_lat"}, n, W);
            check({tag, "_hold"}, {31'h0, hold_ok}, 32'h1);
            check({tag, "_rdy"}, {30'h0, busy, in_ready}, 32'h1);
        end
        check({tag, "_res"}, result, er);
        check({tag, "_flg"}, {28'h0, flags}, {28'h0, ef});
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] held;
        bit          no_ov;

        rst        = 1'b1;
        in_valid   = 1'b0;
        ALUControl = 3'd0;
        src_a      = 32'h0;
        src_b      = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ov", {31'h0, out_valid}, 32'h0);
        check("rst_res", result, 32'h0);
        check("rst_flg", {28'h0, flags}, 32'h0);
        check("rst_rdy", {30'h0, busy, in_ready}, 32'h1);

        // Directed corner cases.
        run_op("add_ovf", 3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        check("add_ovf_exact", {28'h0, flags}, 32'h9);
        run_op("sub_eq", 3'd1, 32'd5, 32'd5, 1'b0);
        check("sub_eq_exact", {28'h0, flags}, 32'h6);
        run_op("sub_lt", 3'd1, 32'd3, 32'd5, 1'b0);
        check("sub_lt_exact", result, 32'hFFFF_FFFE);
        tick();
        check("pulse_end", {31'h0, out_valid}, 32'h0);

        run_op("mul_a", 3'd2, 32'h0000_FFFF, 32'h0001_0001, 1'b1);
        check("mul_a_exact", result, 32'hFFFF_FFFF);
        held = result;
        tick();
        check("mul_a_once", {31'h0, out_valid}, 32'h0);
        check("mul_a_held", result, held);

        run_op("mul_wrap", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("and_b2b", 3'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);
        check("and_b2b_exact", result, 32'h00F0_00F0);

        run_op("sll_mask", 3'd6, 32'h0000_0001, 32'h0000_0023, 1'b0);
        check("sll_mask_exact", result, 32'h0000_0008);
        run_op("srl_31", 3'd7, 32'h8000_0000, 32'd31, 1'b0);

        // Reset in the middle of a multiply aborts it.
        issue(3'd2, 32'h0001_2345, 32'h0000_0FFF);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_ov", {31'h0, out_valid}, 32'h0);
        check("mrst_res", result, 32'h0);
        check("mrst_flg", {28'h0, flags}, 32'h0);
        check("mrst_rdy", {30'h0, busy, in_ready}, 32'h1);
        no_ov = 1'b1;
        repeat (W + 4) begin
            tick();
            if (out_valid) no_ov = 1'b0;
        end
        check("mrst_noov", {31'h0, no_ov}, 32'h1);
        run_op("add_after", 3'd0, 32'd2, 32'd2, 1'b0);
        check("add_after_exact", result, 32'h4);

        // Random operations, back-to-back where possible.
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if (i % 7 == 0) a = 32'h8000_0000;
            if (i % 11 == 0) b = 32'hFFFF_FFFF;
            if (i % 13 == 0) b = a;
            run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, ($urandom_range(0, 1) == 1));
        end

        tick();
        check("final_idle", {31'h0, out_valid}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
